// File: rtl/array_sp_arbiter_if.sv
// ----------------------------------------------------------------------------
// array_sp_arbiter_if
// Requester-side bundle for array_sp_arbiter: two command channels
// (valid/ready, wmode, addr, wdata), two read-response channels
// (valid only, no backpressure), and the init_done status flag.
//   slave  : the arbiter's side (takes commands, returns responses)
//   master : the requesters' side
// ----------------------------------------------------------------------------
interface array_sp_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_wmode;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_wmode;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              init_done;

    modport slave (
        input  req0_valid, req0_wmode, req0_addr, req0_wdata,
        input  req1_valid, req1_wmode, req1_addr, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output init_done
    );

    modport master (
        output req0_valid, req0_wmode, req0_addr, req0_wdata,
        output req1_valid, req1_wmode, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  init_done
    );
endinterface

// File: rtl/array_sp_arbiter.sv
// ----------------------------------------------------------------------------
// array_sp_arbiter
// Shares one single-port RW SRAM macro (1-cycle read latency) between two
// requesters with round-robin arbitration. Optionally zero-fills the whole
// array after reset before accepting traffic.
// Ports:
//   i_clk          clock, all state on posedge
//   i_rst          synchronous active-high reset
//   bus            requester bundle (array_sp_arbiter_if.slave)
//   o_sram_en      -> RW0_en
//   o_sram_wmode   -> RW0_wmode
//   o_sram_addr    -> RW0_addr
//   o_sram_wdata   -> RW0_wdata
//   i_sram_rdata   <- RW0_rdata
// ----------------------------------------------------------------------------
module array_sp_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 32,
    parameter bit INIT_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    array_sp_arbiter_if.slave bus,
    output logic              o_sram_en,
    output logic              o_sram_wmode,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    input  logic [DATA_W-1:0] i_sram_rdata
);

    typedef enum logic [0:0] {S_INIT, S_IDLE} state_t;

    localparam state_t RST_STATE = INIT_EN ? S_INIT : S_IDLE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_last_grant;   // 1: port 1 won the most recent grant
    logic [1:0]        r_rd_pipe;      // per-port read issued last cycle
    logic              w_idle;
    logic              w_g0, w_g1;

    // Outputs are masked while reset is high so nothing is accepted or
    // issued to the macro in the cycle reset rises.
    assign w_idle = (r_state == S_IDLE) && !i_rst;

    // On contention the port that did not win last time goes first.
    assign w_g0 = w_idle && bus.req0_valid && (!bus.req1_valid ||  r_last_grant);
    assign w_g1 = w_idle && bus.req1_valid && (!bus.req0_valid || !r_last_grant);

    assign bus.req0_ready = w_g0;
    assign bus.req1_ready = w_g1;
    assign bus.init_done  = w_idle;

    // The macro holds read data until the next read, so both response
    // channels can look straight at the macro output.
    assign bus.rsp0_valid = r_rd_pipe[0];
    assign bus.rsp1_valid = r_rd_pipe[1];
    assign bus.rsp0_rdata = i_sram_rdata;
    assign bus.rsp1_rdata = i_sram_rdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= RST_STATE;
            r_cnt        <= '0;
            r_last_grant <= 1'b0;
            r_rd_pipe    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_pipe <= {w_g1 && !bus.req1_wmode, w_g0 && !bus.req0_wmode};
            if (w_g0 || w_g1)
                r_last_grant <= w_g1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        o_sram_en    = 1'b0;
        o_sram_wmode = 1'b0;
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        case (r_state)
            S_INIT: begin
                o_sram_en    = !i_rst;
                o_sram_wmode = 1'b1;
                o_sram_addr  = r_cnt;
                w_cnt_nxt    = r_cnt + 1'b1;   // wraps back to 0 after the last entry
                if (r_cnt == LAST_ADDR)
                    w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_g0) begin
                    o_sram_en    = 1'b1;
                    o_sram_wmode = bus.req0_wmode;
                    o_sram_addr  = bus.req0_addr;
                    o_sram_wdata = bus.req0_wdata;
                end else if (w_g1) begin
                    o_sram_en    = 1'b1;
                    o_sram_wmode = bus.req1_wmode;
                    o_sram_addr  = bus.req1_addr;
                    o_sram_wdata = bus.req1_wdata;
                end
            end
            default: w_state_nxt = RST_STATE;
        endcase
    end

endmodule
